// File: rtl/sprite_layer_compositor.sv
// Sprite layer compositor: picks the highest-priority opaque layer per pixel column and
// tracks per-frame layer collisions. Two-stage pipeline, one pixel per cycle, no backpressure.
module sprite_layer_compositor #(
  parameter int unsigned      NUM_LAYERS  = 9,
  parameter int unsigned      PIX_W       = 2,
  parameter int unsigned      PAL_W       = 1,
  parameter logic [PIX_W-1:0] TRANSPARENT = '0,
  localparam int unsigned     HL_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        valid_in,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS*PIX_W-1:0] pixel_data_in,
  input  logic [NUM_LAYERS*PAL_W-1:0] palette_data_in,
  output logic                        valid_out,
  output logic [PIX_W-1:0]            pixel_data_out,
  output logic [PAL_W-1:0]            palette_data_out,
  output logic                        hit,
  output logic [HL_W-1:0]             hit_layer,
  output logic                        collision,
  output logic [NUM_LAYERS-1:0]       collision_mask
);

  logic                        s1_valid_q;
  logic                        s1_fs_q;
  logic [NUM_LAYERS-1:0]       s1_en_q;
  logic [NUM_LAYERS*PIX_W-1:0] s1_pix_q;
  logic [NUM_LAYERS*PAL_W-1:0] s1_pal_q;

  logic [NUM_LAYERS-1:0] opaque;
  logic                  win_found;
  logic [HL_W-1:0]       win_idx;
  logic [PIX_W-1:0]      win_pix;
  logic [PAL_W-1:0]      win_pal;
  logic                  multi;
  logic [NUM_LAYERS-1:0] mask_d;

  // Stage 1: capture the column together with its enables and frame marker.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_fs_q    <= 1'b0;
      s1_en_q    <= '0;
      s1_pix_q   <= '0;
      s1_pal_q   <= '0;
    end else begin
      s1_valid_q <= valid_in;
      s1_fs_q    <= frame_start;
      s1_en_q    <= layer_en;
      s1_pix_q   <= pixel_data_in;
      s1_pal_q   <= palette_data_in;
    end
  end

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = s1_en_q[i] && (s1_pix_q[i*PIX_W +: PIX_W] != TRANSPARENT);
    end
  end

  // Lowest index wins; defaults describe the empty column.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pix   = TRANSPARENT;
    win_pal   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (opaque[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = HL_W'(i);
        win_pix   = s1_pix_q[i*PIX_W +: PIX_W];
        win_pal   = s1_pal_q[i*PAL_W +: PAL_W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more layers are opaque.
  assign multi = |(opaque & (opaque - NUM_LAYERS'(1)));

  always_comb begin
    mask_d = s1_fs_q ? '0 : collision_mask;
    if (s1_valid_q && multi) begin
      mask_d = mask_d | opaque;
    end
  end

  // Stage 2: selection results; pixel fields hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_out        <= 1'b0;
      pixel_data_out   <= '0;
      palette_data_out <= '0;
      hit              <= 1'b0;
      hit_layer        <= '0;
      collision        <= 1'b0;
      collision_mask   <= '0;
    end else begin
      valid_out      <= s1_valid_q;
      hit            <= s1_valid_q && win_found;
      collision      <= s1_valid_q && multi;
      collision_mask <= mask_d;
      if (s1_valid_q) begin
        pixel_data_out   <= win_pix;
        palette_data_out <= win_pal;
        hit_layer        <= win_idx;
      end
    end
  end

endmodule
